// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the wait-state memory responder.
// Holds the FSM state encoding, data/counter widths and the counter preload helper.
package mem_responder_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    // Counter preload on entry to WAIT; zero wait states never enter WAIT.
    function automatic logic [CNT_W-1:0] wait_load(input int unsigned w);
        if (w == 0) begin
            return '0;
        end
        return CNT_W'(w - 1);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, registered read.
// Ports: clk, we/re strobes, word addr, wdata in, rdata (registered) out.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage is deliberately never reset or initialised.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory slave with WAIT_CYCLES wait states and a one-cycle MemReady pulse.
// Ports: clk, Reset (sync, high), MemReq/MemWrite/Adr/WriteData in,
// ReadData/MemReady/MemErr out (data and error are zero unless MemReady).
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              MemReq,
    input  logic              MemWrite,
    input  logic [31:0]       Adr,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              MemReady,
    output logic              MemErr
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = wait_load(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:2]       adr_q, adr_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              rd_q, rd_d;

    logic              take;
    logic              go;
    logic [31:2]       cur_adr;
    logic              cur_wr;
    logic [DATA_W-1:0] cur_wdata;
    logic              oor;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    // With zero wait states the access is served on the accepting edge,
    // so the live inputs stand in for the not-yet-latched copies.
    assign take      = (state_q == ST_IDLE) && MemReq;
    assign cur_adr   = take ? Adr[31:2] : adr_q;
    assign cur_wr    = take ? MemWrite  : wr_q;
    assign cur_wdata = take ? WriteData : wdata_q;
    assign oor       = |cur_adr[31:AW+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        go      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (MemReq) begin
                    adr_d   = Adr[31:2];
                    wr_d    = MemWrite;
                    wdata_d = WriteData;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESPOND;
                        go      = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESPOND;
                    go      = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ready_d = go;
    assign err_d   = go & oor;
    assign rd_d    = go & ~oor & ~cur_wr;

    // Reset suppresses the storage access so an aborted write never lands.
    assign mem_we = go & ~oor & cur_wr & ~Reset;
    assign mem_re = go & ~oor & ~cur_wr & ~Reset;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
        end
    end

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (cur_adr[AW+1:2]),
        .wdata (cur_wdata),
        .rdata (mem_rdata)
    );

    assign ReadData = rd_q ? mem_rdata : '0;
    assign MemReady = ready_q;
    assign MemErr   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (2 and 0 wait states) checked
// every cycle against a transaction-level model plus literal expectations.
module tb_mem_responder;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i [2];
    logic        wr_i  [2];
    logic [31:0] adr_i [2];
    logic [31:0] wd_i  [2];
    logic [31:0] rd_o  [2];
    logic        rdy_o [2];
    logic        err_o [2];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit cmp_en = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .Reset(rst), .MemReq(req_i[0]), .MemWrite(wr_i[0]),
        .Adr(adr_i[0]), .WriteData(wd_i[0]), .ReadData(rd_o[0]),
        .MemReady(rdy_o[0]), .MemErr(err_o[0])
    );

    mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .Reset(rst), .MemReq(req_i[1]), .MemWrite(wr_i[1]),
        .Adr(adr_i[1]), .WriteData(wd_i[1]), .ReadData(rd_o[1]),
        .MemReady(rdy_o[1]), .MemErr(err_o[1])
    );

    function automatic int wc(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    // Model: an access waits its wait states, then responds once,
    // then one edge of cool-down passes before a new accept.
    bit          busy [2];
    bit          cool [2];
    int          rem  [2];
    logic [31:0] la   [2];
    logic [31:0] ld   [2];
    bit          lw   [2];
    logic [31:0] mm   [2][DEPTH];
    bit          kn   [2][DEPTH];
    logic        e_rdy [2];
    logic        e_err [2];
    logic [31:0] e_rd  [2];
    bit          e_chk [2];

    task automatic respond(input int i);
        int idx;
        busy[i]  = 0;
        cool[i]  = 1;
        e_rdy[i] = 1;
        if (la[i] >= 32'(DEPTH * 4)) begin
            e_err[i] = 1;
        end else begin
            idx = int'(la[i] >> 2);
            if (lw[i]) begin
                mm[i][idx] = ld[i];
                kn[i][idx] = 1;
            end else if (kn[i][idx]) begin
                e_rd[i] = mm[i][idx];
            end else begin
                e_chk[i] = 0;
            end
        end
    endtask

    task automatic model_step(input int i);
        e_rdy[i] = 0;
        e_err[i] = 0;
        e_rd[i]  = '0;
        e_chk[i] = 1;
        if (rst) begin
            busy[i] = 0;
            cool[i] = 0;
        end else if (busy[i]) begin
            rem[i]--;
            if (rem[i] <= 0) respond(i);
        end else if (cool[i]) begin
            cool[i] = 0;
        end else if (req_i[i]) begin
            la[i]   = adr_i[i];
            lw[i]   = wr_i[i];
            ld[i]   = wd_i[i];
            busy[i] = 1;
            rem[i]  = wc(i);
            if (rem[i] == 0) respond(i);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) model_step(i);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("u%0d MemReady", i), 32'(rdy_o[i]), 32'(e_rdy[i]));
                check($sformatf("u%0d MemErr", i), 32'(err_o[i]), 32'(e_err[i]));
                if (e_chk[i])
                    check($sformatf("u%0d ReadData", i), rd_o[i], e_rd[i]);
            end
        end
    end

    task automatic access(input int i, input bit w, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd,
                          output logic err, output int lat);
        @(negedge clk);
        req_i[i] = 1; wr_i[i] = w; adr_i[i] = a; wd_i[i] = d;
        lat = 0; rd = '0; err = 0;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (rdy_o[i]) begin
                lat = n; rd = rd_o[i]; err = err_o[i];
                break;
            end
        end
        req_i[i] = 0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          c1, c2, pulses;
    logic [31:0] r1, r2;

    initial begin
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            req_i[i] = 0; wr_i[i] = 0; adr_i[i] = '0; wd_i[i] = '0;
        end
        repeat (3) @(negedge clk);
        cmp_en = 1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset u%0d ready", i), 32'(rdy_o[i]), 0);
            check($sformatf("reset u%0d err", i), 32'(err_o[i]), 0);
            check($sformatf("reset u%0d rdata", i), rd_o[i], 0);
        end
        rst = 0;

        access(0, 1, 32'h10, 32'hDEADBEEF, rd, er, lat);
        check("wr 0x10 latency", lat, 3);
        check("wr 0x10 err", 32'(er), 0);
        check("wr 0x10 rdata", rd, 0);
        access(0, 0, 32'h10, 0, rd, er, lat);
        check("rd 0x10 latency", lat, 3);
        check("rd 0x10 data", rd, 32'hDEADBEEF);
        check("rd 0x10 err", 32'(er), 0);
        access(0, 0, 32'h13, 0, rd, er, lat);
        check("rd 0x13 data", rd, 32'hDEADBEEF);

        access(1, 1, 32'h0, 32'h0BADC0DE, rd, er, lat);
        check("w0 wr latency", lat, 1);
        access(1, 0, 32'h0, 0, rd, er, lat);
        check("w0 rd latency", lat, 1);
        check("w0 rd data", rd, 32'h0BADC0DE);
        @(negedge clk);
        check("w0 ready width", 32'(rdy_o[1]), 0);

        access(0, 1, 32'h0, 32'hCAFEF00D, rd, er, lat);
        access(0, 1, 32'h100, 32'h12345678, rd, er, lat);
        check("oor err", 32'(er), 1);
        check("oor rdata", rd, 0);
        check("oor latency", lat, 3);
        access(0, 0, 32'h0, 0, rd, er, lat);
        check("word0 intact", rd, 32'hCAFEF00D);
        check("word0 err", 32'(er), 0);

        access(0, 1, 32'h8, 32'h11111111, rd, er, lat);
        @(negedge clk);
        req_i[0] = 1; wr_i[0] = 1; adr_i[0] = 32'h8; wd_i[0] = 32'hA5A5A5A5;
        @(negedge clk);
        rst = 1; req_i[0] = 0;
        @(negedge clk);
        rst = 0;
        pulses = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (rdy_o[0]) pulses++;
        end
        check("abort no ready", pulses, 0);
        access(0, 0, 32'h8, 0, rd, er, lat);
        check("abort no commit", rd, 32'h11111111);

        access(0, 1, 32'h4, 32'h44440004, rd, er, lat);
        access(0, 1, 32'hC, 32'hCCCC000C, rd, er, lat);
        @(negedge clk);
        req_i[0] = 1; wr_i[0] = 0; adr_i[0] = 32'h4;
        @(negedge clk);
        adr_i[0] = 32'hC;
        c1 = -100; c2 = 0; r1 = '0; r2 = '0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rdy_o[0]) begin
                if (c1 < 0) begin c1 = cyc; r1 = rd_o[0]; end
                else begin c2 = cyc; r2 = rd_o[0]; break; end
            end
        end
        req_i[0] = 0;
        check("b2b first data", r1, 32'h44440004);
        check("b2b second data", r2, 32'hCCCC000C);
        check("b2b spacing", c2 - c1, 4);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
